// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word reads to a 1-cycle-latency RAM and queues the returned words in a FIFO.
// Optional macro INSTR_PREFETCH_BYPASS_EN forwards return data straight to the fetch stage when the FIFO is empty.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d;

  logic [ADDR_WIDTH-1:0] branch_tgt;
  logic [CNT_W:0]        occupancy;
  logic                  has_space;
  logic                  ret_valid;
  logic                  fifo_valid;
  logic                  bypass_hit;
  logic                  pop;
  logic                  pop_fifo;
  logic                  push_fifo;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^branch_addr_i[1:0];
  assign branch_tgt       = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign occupancy        = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign has_space        = occupancy < (CNT_W + 1)'(DEPTH);
  // A read returning in the branch cycle belongs to the old stream and is dropped.
  assign ret_valid        = inflight_q & ~branch_i;
  assign fifo_valid       = (count_q != '0);
  assign instr_addr_o     = head_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (branch_i) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_en_o   = 1'b0;
    ram_addr_o = next_addr_q;
    if (branch_i) begin
      ram_en_o   = fetch_en_i;
      ram_addr_o = branch_tgt;
    end else if (state_q == RUN) begin
      ram_en_o = fetch_en_i & has_space;
    end
  end

  always_comb begin
`ifdef INSTR_PREFETCH_BYPASS_EN
    bypass_hit    = ret_valid & ~fifo_valid;
    instr_valid_o = fifo_valid | bypass_hit;
    instr_rdata_o = fifo_valid ? mem_q[rd_ptr_q] : (bypass_hit ? ram_rdata_i : '0);
`else
    bypass_hit    = 1'b0;
    instr_valid_o = fifo_valid;
    instr_rdata_o = fifo_valid ? mem_q[rd_ptr_q] : '0;
`endif
  end

  assign pop       = instr_valid_o & instr_ready_i & ~branch_i;
  assign pop_fifo  = pop & fifo_valid;
  assign push_fifo = ret_valid & ~(bypass_hit & instr_ready_i);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    head_addr_d = head_addr_q;
    inflight_d  = ram_en_o;
    next_addr_d = next_addr_q;
    if (ram_en_o) begin
      next_addr_d = ram_addr_o + ADDR_WIDTH'(4);
    end else if (branch_i) begin
      next_addr_d = branch_tgt;
    end
    if (branch_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      head_addr_d = branch_tgt;
    end else begin
      if (push_fifo) begin
        mem_d[wr_ptr_q] = ram_rdata_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_fifo) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        head_addr_d = head_addr_q + ADDR_WIDTH'(4);
      end
      count_d = count_q + CNT_W'(push_fifo) - CNT_W'(pop_fifo);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      next_addr_q <= '0;
      head_addr_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      next_addr_q <= next_addr_d;
      head_addr_q <= head_addr_d;
    end
  end

endmodule
